// File: rtl/ercm_pipe_mul.sv
// Pipelined OR-tree approximate multiplier with masked carry recovery; 3-cycle latency, whole pipe stalls while out_valid & ~out_ready.
// Optional ERCM_EXACT_MODE_EN: per-transaction mode_exact selects the exact product instead.
module ercm_pipe_mul #(
  parameter int WIDTH       = 8,
  parameter int RECOVER_LSB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dat_in_a,
  input  logic [WIDTH-1:0]     dat_in_b,
  input  logic [2*WIDTH-1:0]   rec_mask,
  input  logic                 mode_exact,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dat_o
);

  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = $clog2(WIDTH);
  localparam logic [PW-1:0] LP_REC_KEEP = {PW{1'b1}} << RECOVER_LSB;

  logic              r_s1_vld, r_s2_vld, r_s3_vld;
  logic [WIDTH-1:0]  r_s1_a, r_s1_b;
  logic [PW-1:0]     r_s1_mask;
  logic [PW-1:0]     r_s2_sum, r_s2_vec;
  logic [PW-1:0]     r_s3_dat;

  logic              w_adv;
  logic [PW-1:0]     w_sum, w_vec, w_s3_dat;

  assign w_adv     = ~r_s3_vld | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_vld;
  assign dat_o     = r_s3_dat;

  // Pairwise OR merge; AND-carries collide into vec at their own weight.
  always_comb begin
    logic [PW-1:0] t [WIDTH];
    w_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = r_s1_a[i] ? (PW'(r_s1_b) << i) : '0;
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        w_vec = w_vec | (t[2*j] & t[2*j+1]);
        t[j]  = t[2*j] | t[2*j+1];
      end
    end
    w_sum = t[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_mask <= '0;
      r_s2_sum  <= '0;
      r_s2_vec  <= '0;
      r_s3_dat  <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      if (in_valid) begin
        r_s1_a    <= dat_in_a;
        r_s1_b    <= dat_in_b;
        r_s1_mask <= rec_mask;
      end
      if (r_s1_vld) begin
        r_s2_sum <= w_sum;
        r_s2_vec <= w_vec & r_s1_mask & LP_REC_KEEP;
      end
      if (r_s2_vld) begin
        r_s3_dat <= w_s3_dat;
      end
    end
  end

`ifdef ERCM_EXACT_MODE_EN
  logic          r_s1_mode, r_s2_mode;
  logic [PW-1:0] r_s2_exact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_mode  <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_exact <= '0;
    end else if (w_adv) begin
      if (in_valid) begin
        r_s1_mode <= mode_exact;
      end
      if (r_s1_vld) begin
        r_s2_mode  <= r_s1_mode;
        r_s2_exact <= PW'(r_s1_a) * PW'(r_s1_b);
      end
    end
  end

  assign w_s3_dat = r_s2_mode ? r_s2_exact : (r_s2_sum + r_s2_vec);
`else
  logic w_unused_mode;
  assign w_unused_mode = mode_exact;
  assign w_s3_dat      = r_s2_sum + r_s2_vec;
`endif

endmodule

// File: tb/tb_ercm_pipe_mul.sv
// Bench: two instances (RECOVER_LSB=4 and 0) sharing stimulus, scoreboarded against a queue-based reference model.
module tb_ercm_pipe_mul;

  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [TW-1:0]   a, b;
  logic [2*TW-1:0] mask;
  logic            mode;
  logic            out_ready;
  logic            rdy_l, vld_l, rdy_z, vld_z;
  logic [2*TW-1:0] dat_l, dat_z;

  ercm_pipe_mul #(.WIDTH(TW), .RECOVER_LSB(4)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l),
    .dat_in_a(a), .dat_in_b(b), .rec_mask(mask), .mode_exact(mode),
    .out_valid(vld_l), .out_ready(out_ready), .dat_o(dat_l));

  ercm_pipe_mul #(.WIDTH(TW), .RECOVER_LSB(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_z),
    .dat_in_a(a), .dat_in_b(b), .rec_mask(mask), .mode_exact(mode),
    .out_valid(vld_z), .out_ready(out_ready), .dat_o(dat_z));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pop  = 0;
  logic [15:0] q_l[$];
  logic [15:0] q_z[$];
  logic [15:0] exp_l, exp_z, held_dat;
  bit          stall_prev = 1'b0;
  bit          acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: list of shifted partial products merged in pairs until one remains.
  function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [15:0] mm, input int rlsb);
    logic [15:0] t[$];
    logic [15:0] nt[$];
    logic [15:0] vec;
    logic [15:0] keep;
    vec = '0;
    for (int i = 0; i < TW; i++) t.push_back(ma[i] ? (16'(mb) << i) : 16'd0);
    while (t.size() > 1) begin
      nt = {};
      for (int j = 0; j < t.size(); j += 2) begin
        vec = vec | (t[j] & t[j+1]);
        nt.push_back(t[j] | t[j+1]);
      end
      t = nt;
    end
    keep = (rlsb >= 16) ? 16'd0 : (16'hFFFF << rlsb);
    return t[0] + (vec & mm & keep);
  endfunction

  task automatic set_op(input bit v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] mm, input bit md, input bit ordy);
    in_valid  = v;
    a         = aa;
    b         = bb;
    mask      = mm;
    mode      = md;
    out_ready = ordy;
    exp_l     = model(aa, bb, mm, 4);
    exp_z     = model(aa, bb, mm, 0);
`ifdef ERCM_EXACT_MODE_EN
    if (md) begin
      exp_l = 16'(aa) * 16'(bb);
      exp_z = 16'(aa) * 16'(bb);
    end
`endif
  endtask

  // Evaluate handshake just after a falling edge, then advance one clock.
  task automatic cycle(output bit accepted);
    #1;
    check("vld_match", vld_z, vld_l);
    if (stall_prev) begin
      check("hold_dat", dat_l, held_dat);
      check("hold_vld", vld_l, 1);
    end
    stall_prev = vld_l && !out_ready;
    if (stall_prev) begin
      held_dat = dat_l;
      check("rdy_stall", rdy_l, 0);
    end
    if (vld_l && out_ready) begin
      n_pop++;
      if (q_l.size() == 0 || q_z.size() == 0) check("spurious_out", 1, 0);
      else begin
        check("dat_rlsb4", dat_l, q_l.pop_front());
        check("dat_rlsb0", dat_z, q_z.pop_front());
      end
    end
    accepted = in_valid && rdy_l;
    if (accepted) begin
      q_l.push_back(exp_l);
      q_z.push_back(exp_z);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] bp_a [5] = '{8'd3, 8'd200, 8'd17, 8'd255, 8'd9};
  logic [7:0] bp_b [5] = '{8'd48, 8'd7, 8'd16, 8'd129, 8'd99};

  initial begin
    rst_n = 1'b0;
    set_op(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_vld", vld_l, 0);
      check("rst_dat", dat_l, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", rdy_l, 1);

    // Latency: carry at weight 1 recovered only when RECOVER_LSB=0.
    set_op(1, 3, 3, 16'hFFFF, 0, 1);
    exp_l = 16'd7;
    exp_z = 16'd9;
    cycle(acc);
    check("acc_first", acc, 1);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("lat_vld", vld_l, (k == 3) ? 1 : 0);
      cycle(acc);
    end

    // Directed values with fixed expectations.
    set_op(1, 3, 48, 16'hFFFF, 0, 1);  exp_l = 16'd144; exp_z = 16'd144; cycle(acc);
    set_op(1, 3, 48, 16'h0000, 0, 1);  exp_l = 16'd112; exp_z = 16'd112; cycle(acc);
    set_op(1, 1, 200, 16'hFFFF, 0, 1); exp_l = 16'd200; exp_z = 16'd200; cycle(acc);
    set_op(1, 16, 17, 16'hFFFF, 0, 1); exp_l = 16'd272; exp_z = 16'd272; cycle(acc);
    set_op(1, 0, 255, 16'hFFFF, 0, 1); exp_l = 16'd0;   exp_z = 16'd0;   cycle(acc);
    set_op(1, 255, 255, 16'hFFFF, 1, 1); cycle(acc);
    set_op(1, 255, 255, 16'hFFFF, 0, 1); cycle(acc);
    set_op(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(acc);
    check("directed_drain", q_l.size(), 0);

    // Backpressure: output stalled for 4 cycles in mid-stream.
    n_pop = 0;
    begin
      int idx = 0;
      for (int c = 0; c < 20; c++) begin
        if (idx < 5) set_op(1, bp_a[idx], bp_b[idx], 16'hFFFF, 0, !(c >= 4 && c < 8));
        else         set_op(0, 0, 0, 0, 0, !(c >= 4 && c < 8));
        cycle(acc);
        if (acc) idx++;
      end
      check("bp_accepted", idx, 5);
    end
    check("bp_emitted", n_pop, 5);

    // Asynchronous reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      set_op(1, 8'(k + 5), 8'(k + 11), 16'hFFFF, 0, 1);
      cycle(acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vld", vld_l, 0);
    check("midrst_dat", dat_l, 0);
    q_l.delete();
    q_z.delete();
    stall_prev = 1'b0;
    set_op(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("no_stale", vld_l, 0);
      cycle(acc);
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [15:0] mm;
      case ($urandom_range(0, 3))
        0:       mm = 16'h0000;
        1:       mm = 16'hFFFF;
        default: mm = 16'($urandom);
      endcase
      set_op($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), mm,
             1'($urandom), $urandom_range(0, 9) < 7);
      cycle(acc);
    end

    set_op(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10 && q_l.size() != 0; k++) cycle(acc);
    check("final_drain_l", q_l.size(), 0);
    check("final_drain_z", q_z.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ercm_pipe_mul.md
Name: ercm_pipe_mul

Overview:
- Parametrised, pipelined successor to the team's 8-bit error-recovery approximate multiplier.
- Unsigned WIDTH x WIDTH product:
  - partial products are merged pairwise in a binary OR-compression tree;
  - the discarded AND-carries are collected into a recovery vector;
  - the recovery vector, gated by a runtime column mask, is added back in a final CPA.
- 3-stage pipeline with valid/ready handshake; sits between operand FIFOs and the accumulator in the approximate-MAC datapath.

Parameters:
- WIDTH, 8, operand width; power of two, 4..16.
- RECOVER_LSB, 4, recovery-vector bits below this weight are forced to 0 (bypass lower bits).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dat_in_a  in  WIDTH  multiplicand.
- dat_in_b  in  WIDTH  multiplier.
- rec_mask  in  2*WIDTH  per-weight recovery enable; bit w gates recovery bit w. Sampled with operands.
- mode_exact  in  1  exact-product request (only used under the optional feature).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dat_o  out  2*WIDTH  product.

Behaviour:
- Partial products: p_i = (dat_in_a[i] ? dat_in_b : 0) << i, for i = 0..WIDTH-1.
- Tree: log2(WIDTH) levels. At each level adjacent terms (x, y) combine into s = x | y and c = x & y, bitwise over absolute weights.
  - Every c bit of weight w is ORed into recovery vector vec[w]; it is re-added at the same weight, since x + y = (x|y) + (x&y).
  - Collisions of several carries at one weight are lost through the OR; this is the approximation.
- Final: dat_o = S + (vec & rec_mask & ~((1<<RECOVER_LSB)-1)).
  - S is the tree root.
  - Addition is full-width 2*WIDTH, carry out discarded. Width is sufficient: the result never exceeds the exact product.
- Pipeline:
  - S1 registers operands, rec_mask and mode.
  - S2 registers S and vec.
  - S3 registers dat_o.
  - Latency is 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when not stalled.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - The whole pipe advances only when in_ready = 1 (global enable). Each stage carries a valid bit; bubbles propagate.
  - While out_valid = 1 and out_ready = 0: dat_o and out_valid hold stable and no stage updates.
  - Simultaneous accept and emit in the same cycle is allowed; full throughput is 1 result per cycle.
- Reset (async, any time, including mid-operation): all valid bits 0, all data registers 0, so out_valid = 0 and dat_o = 0. In-flight operations are discarded. in_ready = 1 once reset is released.
- rec_mask = 0 or RECOVER_LSB >= 2*WIDTH: result is the pure OR tree S.

Optional Feature:
- Macro ERCM_EXACT_MODE_EN.
- Defined:
  - mode_exact is pipelined with its operands.
  - When 1, S3 outputs the exact product dat_in_a*dat_in_b, computed in S2/S3 alongside the approximate path, instead of the approximate result.
  - Mode may change per transaction; there is no flush.
- Undefined: mode_exact is ignored (no logic attached) and the result is always approximate.

Test Plan:
- Reset/latency: rst_n low 2 cycles, then in_valid=1, a=3, b=3, rec_mask=all ones, out_ready=1 (WIDTH=8, RECOVER_LSB=4) -> out_valid=0, dat_o=0 during reset; 3 cycles after accept dat_o=7 (carry at weight 1 bypassed).
- Recovery: a=3, b=48, rec_mask=all ones -> dat_o=144 (exact); same operands with rec_mask=0 -> dat_o=112.
- Bypass param: RECOVER_LSB=0, a=3, b=3, rec_mask=all ones -> dat_o=9; a=1, b=200 -> 200; a=16, b=17 -> 272; a=0, b=255 -> 0.
- Backpressure: stream 5 operand pairs with out_ready low for 4 cycles mid-stream -> in_ready=0 while out_valid=1, dat_o stable, all 5 results emitted in order, none lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately (async); after release, no stale results appear.
- ERCM_EXACT_MODE_EN defined: a=255, b=255, mode_exact=1 -> 65025; next cycle same operands, mode_exact=0 -> approximate value equal to the reference model, back-to-back.
